// File: rtl/bsram_pkg.sv
// bsram_pkg: shared state encoding and default widths for the block RAM burst master
package bsram_pkg;
   localparam int BSRAM_AW = 13;
   localparam int BSRAM_DW = 8;
   localparam int BSRAM_LEN_W = 8;
   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, DRAIN = 2'd3} state_t;
endpackage

// File: rtl/bsram_resp_fifo.sv
// bsram_resp_fifo: 2-entry response buffer with occupancy count for read credit checks
module bsram_resp_fifo #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);
   logic [W-1:0] mem [2];
   logic wp, rp;
   assign dout = mem[rp];
   // storage and pointers; a push and pop in the same cycle leave occupancy unchanged
   always_ff @(posedge clk) begin
      if (reset) begin
         wp <= 1'b0;
         rp <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) begin
            mem[wp] <= din;
            wp <= ~wp;
         end
         if (pop) rp <= ~rp;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: rtl/bsram_burst_master.sv
// bsram_burst_master: burst read/write initiator for a 1-cycle-latency single-port block RAM
module bsram_burst_master
   import bsram_pkg::*;
#(
   parameter int AW = BSRAM_AW,
   parameter int DW = BSRAM_DW,
   parameter int LEN_W = BSRAM_LEN_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [AW-1:0]    cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [DW-1:0]    wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [DW-1:0]    rd_data,
   output logic             rd_last,
   output logic             busy,
   output logic             ram_ce,
   output logic             ram_oce,
   output logic             ram_wre,
   output logic             ram_reset,
   output logic [AW-1:0]    ram_ad,
   output logic [DW-1:0]    ram_din,
   input  logic [DW-1:0]    ram_dout
);
   state_t state;
   logic [AW-1:0] addr;
   logic [LEN_W-1:0] cnt;
   logic in_flight, in_flight_last, wr_fire, issue, pop;
   logic [1:0] fifo_count;
   logic [DW:0] head;

   assign rd_valid = !reset && fifo_count != 2'd0;
   assign pop = rd_valid && rd_ready;
   assign rd_data = head[DW-1:0];
   assign rd_last = rd_valid && head[DW];
   assign cmd_ready = !reset && state == IDLE && !rd_valid;
   assign wr_ready = !reset && state == WRITE;
   assign wr_fire = wr_valid && wr_ready;
   assign issue = !reset && state == READ &&
                  ({1'b0, fifo_count} + {2'b0, in_flight} - {2'b0, pop} < 3'd2);
   assign ram_ce = wr_fire || issue;
   assign ram_wre = wr_fire;
   assign ram_ad = ram_ce ? addr : '0;
   assign ram_din = wr_fire ? wr_data : '0;
   assign ram_oce = 1'b1;
   assign ram_reset = reset;
   assign busy = state != IDLE || rd_valid;

   bsram_resp_fifo #(.W(DW + 1)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(in_flight),
      .din({in_flight_last, ram_dout}),
      .pop(pop),
      .dout(head),
      .count(fifo_count)
   );

   // burst sequencing: load on accept, step address/count per beat, drain reads before idling
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         addr <= '0;
         cnt <= '0;
         in_flight <= 1'b0;
         in_flight_last <= 1'b0;
      end else begin
         in_flight <= issue;
         in_flight_last <= issue && cnt == '0;
         if (cmd_valid && cmd_ready) begin
            state <= cmd_write ? WRITE : READ;
            addr <= cmd_addr;
            cnt <= cmd_len;
         end else if (wr_fire || issue) begin
            addr <= addr + AW'(1);
            cnt <= cnt - LEN_W'(1);
            if (cnt == '0) state <= wr_fire ? IDLE : DRAIN;
         end else if (state == DRAIN && !rd_valid && !in_flight) begin
            state <= IDLE;
         end
      end
   end
endmodule
